// File: rtl/arith_result_serializer_if.sv
// Upstream result handshake into the serializer.
// The master drives a 6-bit result and its mode bit under valid/ready.
interface arith_result_serializer_if;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_result;
    logic       in_mode;

    modport master (
        output in_valid,
        output in_result,
        output in_mode,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_result,
        input  in_mode,
        output in_ready
    );
endinterface

// File: rtl/arith_result_serializer.sv
// Arithmetic result serializer.
// Buffers {mode, result} words in a small FIFO and sends each one as a
// 10-bit frame on tx_out: start(0), result[0..5], mode, even parity, stop(1).
// Back-to-back frames leave STOP straight into START with no idle gap.
module arith_result_serializer #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    arith_result_serializer_if.slave  up,
    input  logic                      clear_ovf,
    output logic                      tx_out,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and pointers; the pointers carry one extra wrap bit so
    // full and empty can be told apart when the index bits match.
    logic [6:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    // Transmitter state
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cyc;
    logic [CW-1:0] w_cyc_next;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_next;
    logic [6:0]    r_shift;
    logic [6:0]    w_shift_next;
    logic          r_parity;
    logic          w_parity_next;
    logic          r_tx;
    logic          w_tx_next;
    logic          r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_last_cyc;
    logic [6:0]    w_head;

    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_push     = up.in_valid && !w_full;
    assign w_last_cyc = (r_cyc == LAST_CYC);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    // A pop only looks at registered occupancy, so a word written this edge
    // cannot be popped before the next one.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last_cyc));

    assign up.in_ready = !w_full;
    assign tx_out      = r_tx;
    assign busy        = r_busy;
    assign count       = r_count;
    assign ovf         = r_ovf;

    // FIFO data write
    // NOTE: storage has no reset; the pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {up.in_mode, up.in_result};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Setting wins over a same-cycle clear.
            if (up.in_valid && w_full) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Next-state, bit timing, shift/parity load and next line level
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next  = r_state;
        w_cyc_next    = r_cyc;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = 1'b1;

        if (r_state != S_IDLE) begin
            w_cyc_next = w_last_cyc ? '0 : r_cyc + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_next = S_START;
                    w_cyc_next   = '0;
                end
            end
            S_START: begin
                if (w_last_cyc) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_last_cyc) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == LAST_BIT) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_last_cyc) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last_cyc) begin
                    w_state_next = w_pop ? S_START : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cyc_next   = '0;
            end
        endcase

        // The head word and its even parity are captured on every pop.
        if (w_pop) begin
            w_shift_next  = w_head;
            w_parity_next = ^w_head;
        end

        // The line level is registered, so derive it from the next state.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Transmitter registers; reset drops any frame in flight and idles the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cyc    <= w_cyc_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_arith_result_serializer.sv
// Directed bench for arith_result_serializer (DEPTH=4, CLKS_PER_BIT=4).
module tb_arith_result_serializer;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_ovf;
    logic       tx_out;
    logic       busy;
    logic [2:0] count;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;

    arith_result_serializer_if u_if ();

    arith_result_serializer #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .up        (u_if.slave),
        .clear_ovf (clear_ovf),
        .tx_out    (tx_out),
        .busy      (busy),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] result;
        logic       mode;
        logic       exp_parity;
    } vec_t;

    typedef struct {
        logic [2:0] exp_count;
        logic       exp_ready;
        logic       exp_ovf;
    } fill_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Serial bit k of a frame: start, result LSB first, mode, parity, stop.
    function automatic logic frame_bit(input logic [5:0] r, input logic m,
                                       input logic p, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 6) return r[k-1];
        else if (k == 7) return m;
        else if (k == 8) return p;
        else             return 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [7];
        fill_t fills [6];
        logic [5:0] fill_par;
        vec_t  drain [4];
        int busy_n;
        int gap_n;
        int err_n;
        int max_cnt;
        logic [7:0] field;

        // Single-frame vectors; parity is hand-counted over the 7 data bits.
        vecs[0] = '{6'd35, 1'b0, 1'b1};
        vecs[1] = '{6'd13, 1'b1, 1'b0};
        vecs[2] = '{6'd0,  1'b0, 1'b0};
        vecs[3] = '{6'd63, 1'b0, 1'b0};
        vecs[4] = '{6'd15, 1'b1, 1'b1};
        vecs[5] = '{6'd42, 1'b0, 1'b1};
        vecs[6] = '{6'd7,  1'b1, 1'b0};

        fills[0] = '{3'd1, 1'b1, 1'b0};
        fills[1] = '{3'd1, 1'b1, 1'b0};
        fills[2] = '{3'd2, 1'b1, 1'b0};
        fills[3] = '{3'd3, 1'b1, 1'b0};
        fills[4] = '{3'd4, 1'b0, 1'b0};
        fills[5] = '{3'd4, 1'b0, 1'b1};
        // Parity of values 1..5 with mode 0 (index = value - 1).
        fill_par = 6'b001011;

        drain[0] = '{6'd50, 1'b0, 1'b1};
        drain[1] = '{6'd9,  1'b1, 1'b1};
        drain[2] = '{6'd33, 1'b0, 1'b0};
        drain[3] = '{6'd14, 1'b1, 1'b0};

        rst            = 1'b1;
        clear_ovf      = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_result = '0;
        u_if.in_mode   = 1'b0;

        // Reset state
        #12;
        check("reset tx_out", 32'(tx_out), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset in_ready", 32'(u_if.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames from the vector table
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            u_if.in_valid  = 1'b1;
            u_if.in_result = vecs[v].result;
            u_if.in_mode   = vecs[v].mode;
            @(posedge clk);
            #1;
            u_if.in_valid = 1'b0;
            @(posedge clk);
            busy_n = 0;
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (busy) busy_n++;
                if (c == 0) check($sformatf("vec%0d count after pop", v), 32'(count), 32'd0);
                if ((c % CPB) == CPB / 2) begin
                    check($sformatf("vec%0d bit%0d", v, c / CPB), 32'(tx_out),
                          32'(frame_bit(vecs[v].result, vecs[v].mode, vecs[v].exp_parity, c / CPB)));
                end
                @(posedge clk);
            end
            @(negedge clk);
            check($sformatf("vec%0d busy cycles", v), 32'(busy_n), 32'(FRAME));
            check($sformatf("vec%0d idle busy", v), 32'(busy), 32'd0);
            check($sformatf("vec%0d idle tx", v), 32'(tx_out), 32'd1);
        end

        // Fill and overflow: in_valid held for 6 edges with values 1..6
        for (int i = 0; i < 6; i++) begin
            u_if.in_valid  = 1'b1;
            u_if.in_result = 6'(i + 1);
            u_if.in_mode   = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("fill edge%0d count", i + 1), 32'(count), 32'(fills[i].exp_count));
            check($sformatf("fill edge%0d in_ready", i + 1), 32'(u_if.in_ready), 32'(fills[i].exp_ready));
            check($sformatf("fill edge%0d ovf", i + 1), 32'(ovf), 32'(fills[i].exp_ovf));
        end
        // Frame 1 started after edge 2; this negedge is cycle 4 of it.
        u_if.in_valid = 1'b0;
        clear_ovf     = 1'b1;
        @(negedge clk);
        check("ovf clear alone", 32'(ovf), 32'd0);
        u_if.in_valid  = 1'b1;
        u_if.in_result = 6'd7;
        @(negedge clk);
        check("ovf set beats clear", 32'(ovf), 32'd1);
        check("full push rejected", 32'(count), 32'd4);
        u_if.in_valid = 1'b0;
        @(negedge clk);
        check("ovf cleared next", 32'(ovf), 32'd0);
        clear_ovf = 1'b0;
        gap_n = 0;
        for (int c = 8; c < 5 * FRAME; c++) begin
            @(negedge clk);
            if (!busy) gap_n++;
            if ((c % CPB) == CPB / 2) begin
                check($sformatf("fill frame%0d bit%0d", c / FRAME, (c % FRAME) / CPB), 32'(tx_out),
                      32'(frame_bit(6'(c / FRAME + 1), 1'b0, fill_par[c / FRAME], (c % FRAME) / CPB)));
            end
        end
        check("fill no busy gap", 32'(gap_n), 32'd0);
        @(negedge clk);
        check("fill drained busy", 32'(busy), 32'd0);
        check("fill drained count", 32'(count), 32'd0);
        check("fill drained tx", 32'(tx_out), 32'd1);

        // Reset mid-frame with two entries queued
        repeat (3) @(negedge clk);
        u_if.in_valid  = 1'b1;
        u_if.in_result = 6'd35;
        u_if.in_mode   = 1'b0;
        @(negedge clk);
        u_if.in_result = 6'd20;
        @(negedge clk);
        u_if.in_result = 6'd9;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        check("rst pre count", 32'(count), 32'd2);
        repeat (12) @(negedge clk);
        check("rst pre tx data bit2", 32'(tx_out), 32'd0);
        check("rst pre busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst async tx", 32'(tx_out), 32'd1);
        check("rst async busy", 32'(busy), 32'd0);
        check("rst async count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        err_n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) err_n++;
        end
        check("post rst line idle", 32'(err_n), 32'd0);
        check("post rst count", 32'(count), 32'd0);

        // Drain while filling: one push per frame, landing in STOP
        @(negedge clk);
        u_if.in_valid  = 1'b1;
        u_if.in_result = drain[0].result;
        u_if.in_mode   = drain[0].mode;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        @(posedge clk);
        max_cnt = 0;
        err_n   = 0;
        field   = '0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge clk);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if ((c % CPB) == CPB / 2) begin
                if ((c % FRAME) / CPB == 0 && tx_out !== 1'b0) err_n++;
                else if ((c % FRAME) / CPB == 9 && tx_out !== 1'b1) err_n++;
                else if ((c % FRAME) / CPB >= 1 && (c % FRAME) / CPB <= 8)
                    field[(c % FRAME) / CPB - 1] = tx_out;
            end
            if ((c % FRAME) == FRAME - 1) begin
                check($sformatf("drain frame%0d data", c / FRAME), 32'(field[6:0]),
                      32'({drain[c / FRAME].mode, drain[c / FRAME].result}));
                check($sformatf("drain frame%0d parity", c / FRAME), 32'(field[7]),
                      32'(drain[c / FRAME].exp_parity));
                check($sformatf("drain frame%0d even", c / FRAME), 32'(^field), 32'd0);
            end
            if ((c % FRAME) == FRAME - 2 && (c / FRAME) < 3) begin
                u_if.in_valid  = 1'b1;
                u_if.in_result = drain[c / FRAME + 1].result;
                u_if.in_mode   = drain[c / FRAME + 1].mode;
            end
            if ((c % FRAME) == FRAME - 1) u_if.in_valid = 1'b0;
            @(posedge clk);
        end
        check("drain framing", 32'(err_n), 32'd0);
        check("drain max count", 32'(max_cnt), 32'd1);
        check("drain ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        check("drain end busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_result_serializer.md
Name: arith_result_serializer

Overview:
- Downstream stage of the 3-bit adder/multiplier datapath.
- Accepts each 6-bit result and its mode bit (1 = add, 0 = multiply) over a valid/ready handshake and buffers it in a small FIFO.
- Transmits each entry as a framed, even-parity serial word on a single output pin.
- Lets a 6-bit parallel result leave the chip on one uo_out bit while upstream keeps issuing operations.

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2)
CLKS_PER_BIT, 4, clock cycles per serial bit (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream result is valid this cycle
in_ready  output  1  FIFO can accept; combinational, equals !full
in_result  input  6  result value; add results are zero-extended (bits 5:4 = 0)
in_mode  input  1  1 = adder result, 0 = multiplier result
clear_ovf  input  1  synchronous clear of the ovf flag
tx_out  output  1  serial line, idles high
busy  output  1  high whenever a frame is in flight
count  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the frame in flight
ovf  output  1  sticky flag: in_valid was seen while full

Behaviour:
- Reset (async, immediate on rst rise):
  - tx_out=1, busy=0, count=0, ovf=0.
  - FIFO pointers cleared, FSM returns to IDLE, bit and cycle counters cleared.
  - Reset mid-frame aborts the frame; the line returns high at once, and nothing resumes after release.
- Push:
  - Occurs on an edge with in_valid && in_ready; writes {in_mode, in_result}.
  - in_valid while full: no write, ovf<=1.
  - ovf set and clear_ovf in the same cycle: set wins.
- Pop: occurs on an edge where the FSM is IDLE, or at the last cycle of STOP, and count>0.
  - The head is loaded into a 7-bit shift register.
  - Parity is latched as the XOR of the 7 bits (even parity).
  - Next state is START.
- Simultaneous push and pop: both occur; count unchanged.
  - With DEPTH full, in_ready=0, so push is blocked even if a pop happens that edge.
  - There is no same-cycle bypass: an entry pushed at edge N is popped no earlier than edge N+1.
- FSM: IDLE -> START -> DATA -> PARITY -> STOP -> (START if count>0, else IDLE).
  - Every non-IDLE state lasts CLKS_PER_BIT cycles, timed by the cycle counter.
  - DATA lasts 7 bit periods, LSB first: result[0]..result[5], then mode.
- tx_out is registered: 1 in IDLE, 0 in START, shift[0] in DATA, parity in PARITY, 1 in STOP.
- Frame length: 10 bits = 10*CLKS_PER_BIT cycles.
- Back-to-back frames have no idle gap: STOP is followed directly by START.
- busy=1 in every state except IDLE, updated on the same edge as the state.
- Latency: a push at edge N into an empty, idle block pops at edge N+1; tx_out falls and busy rises after edge N+1.
- count is registered; it increments on push and decrements on pop.
- FIFO pointers wrap modulo DEPTH; full is detected with an extra pointer bit.

Test Plan:
- Multiply frame, CLKS_PER_BIT=4: push result=35, mode=0, idle FIFO.
  - tx_out bit sequence is 0, 1,1,0,0,0,1, 0, parity 1, stop 1, each held 4 cycles.
  - busy high for exactly 40 cycles.
- Add frame: push result=13, mode=1.
  - Data bits are 1,0,1,1,0,0 then mode 1; parity 0; stop 1.
  - Line returns high with busy=0 after 40 cycles.
- Fill and overflow: hold in_valid for 6 consecutive edges with values 1..6.
  - Edge 1 push (count=1); edge 2 push+pop (count=1); edges 3-5 pushes (count=4, in_ready=0).
  - Edge 6 is not accepted and ovf=1.
  - Frames carry 1..5 back-to-back with no high gap between STOP and START.
- ovf clear priority: with FIFO full, drive in_valid=1 and clear_ovf=1 together -> ovf stays 1.
  - Next cycle, in_valid=0 and clear_ovf=1 -> ovf=0.
- Reset mid-frame: assert rst during the 3rd DATA bit with 2 entries queued.
  - tx_out=1, busy=0, count=0 immediately, before the next clk edge.
  - After release, tx_out stays high for 50 cycles with no pushes.
- Drain while filling: push one entry every 40 cycles, phase-aligned to STOP.
  - count never exceeds 1, ovf stays 0, and every frame's parity bit makes the 8-bit data+parity field even.
